// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit 0, DATA_BITS payload bits LSB first,
// stop bit 1, with din sampled only on bit_en strobes.
// Valid/ready semantics: there is no back-pressure. dout_valid (or frame_err)
// is a one-clock pulse that the consumer must take in the cycle it is high.
// dout holds the last good payload until the next good frame overwrites it.
module serial_frame_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 bit_en,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [7:0]           frame_cnt,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    STOP      = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;

  // Next-state and output decode; strobe-free cycles only clear the pulses.
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (bit_en && !din) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_en) begin
          sreg_d    = {din, sreg_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_en) begin
          if (din) begin
            dout_d       = sreg_q;
            dout_valid_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
            state_d      = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // Line must return high before a new start bit can be trusted.
        if (bit_en && din) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DATA) || (state_d == STOP);
  end

  // State and output registers; reset overrides any strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;
  assign frame_cnt  = frame_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning number of payload bits per frame (legal range 2..16).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 din  input  1  serial line from the upstream shift register; idles high.
REQ-005 bit_en  input  1  sample strobe; din is sampled only on edges where bit_en=1.
REQ-006 dout  output  DATA_BITS  last correctly framed payload.
REQ-007 dout_valid  output  1  one-cycle pulse when dout has just been updated.
REQ-008 frame_err  output  1  one-cycle pulse when the stop bit sampled 0.
REQ-009 busy  output  1  high while a frame is in progress (states DATA, STOP).
REQ-010 frame_cnt  output  8  count of good frames, modulo 256.

Function
REQ-011 The frame format SHALL be: start bit 0, DATA_BITS payload bits LSB first, stop bit 1.
REQ-012 The FSM SHALL have four states: IDLE, DATA, STOP and WAIT_HIGH.
REQ-013 In IDLE with bit_en=1 and din=0, the FSM SHALL go to DATA and clear bit_cnt; din=1 or bit_en=0 holds IDLE.
REQ-014 In DATA, each bit_en=1 edge SHALL shift din in at the MSB (sreg <= {din, sreg[DATA_BITS-1:1]}) and increment bit_cnt.
REQ-015 On the edge that samples payload bit DATA_BITS-1, the FSM SHALL go to STOP.
REQ-016 In STOP with bit_en=1 and din=1: on that same edge dout <= sreg, dout_valid=1, frame_cnt increments, and the FSM goes to IDLE.
REQ-017 In STOP with bit_en=1 and din=0: on that same edge frame_err=1, dout and frame_cnt hold, and the FSM goes to WAIT_HIGH.
REQ-018 In WAIT_HIGH, the FSM SHALL go to IDLE only on a bit_en=1 edge with din=1; a 0 there is never a start bit.
REQ-019 dout_valid and frame_err SHALL each be high for exactly one clock after the setting edge, and SHALL never be high together.
REQ-020 A start bit sampled on the first bit_en edge after a good stop bit SHALL be accepted (back-to-back frames, no idle gap required).
REQ-021 Edges with bit_en=0 SHALL leave state, sreg and bit_cnt unchanged; only the dout_valid and frame_err pulses clear.
REQ-022 frame_cnt SHALL wrap 255 -> 0 with no flag.
REQ-023 busy SHALL be a registered decode of state: 1 in DATA and STOP, 0 in IDLE and WAIT_HIGH.
REQ-024 All outputs SHALL be registered, with no combinational path from din or bit_en to any output.

Reset
REQ-025 With rst=1 at a clock edge: state=IDLE, sreg=0, bit_cnt=0, dout=0, dout_valid=0, frame_err=0, busy=0, frame_cnt=0.
REQ-026 rst SHALL take priority over bit_en and din.
REQ-027 rst asserted mid-frame SHALL discard the partial frame with no dout_valid or frame_err pulse.
REQ-028 After rst is released, the first start bit SHALL be accepted from IDLE.

Verification
REQ-029 Good frame. bit_en=1 constant, din = 1,1, 0, 1,0,1,0,0,1,0,1, 1 (0xA5 LSB first) -> dout=8'hA5, dout_valid high 1 cycle after the stop edge, frame_cnt=1, busy high for 9 cycles.
REQ-030 Framing error. Same payload with stop bit 0, then din held 0 for 5 strobes -> frame_err 1 cycle, dout=0 unchanged, frame_cnt=0, busy=0; FSM stays in WAIT_HIGH until din=1; a following good 0x3C frame -> dout=8'h3C.
REQ-031 Strobed rate. bit_en high every 4th cycle, din changed only on strobe cycles, frame 0x5A -> dout=8'h5A, with identical results to the bit_en=1 case.
REQ-032 Back-to-back. Frames 0x01 then 0xFF with the second start bit directly after the first stop bit -> two dout_valid pulses 10 strobes apart, frame_cnt=2.
REQ-033 Reset mid-frame. rst=1 for 1 cycle after the 4th payload bit, then a full frame 0x81 -> no pulse from the aborted frame, dout=8'h81, frame_cnt=1.
REQ-034 Wrap. 256 good frames -> frame_cnt returns to 0 on the 256th dout_valid.
